udp_rx: RTL

- Byte-wide Ethernet/IPv4/UDP receiver on the MII-style receive side. It is the counterpart of the board's UDP transmitter.
- Strips the preamble/SFD, filters on MAC, IP and UDP fields, and verifies the IPv4 header checksum.
- Packs the UDP payload little-endian into 32-bit words and writes them into the shared packet RAM.
- Signals frame completion or abort to the controller.

---
 rtl/udp_rx.sv | 274 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/udp_rx.sv
// udp_rx: byte-wide Ethernet/IPv4/UDP receiver.
// Removes the preamble and SFD, then filters the frame on destination MAC,
// EtherType, IPv4 version/IHL, protocol, destination IP and destination UDP
// port. It checks the IPv4 header checksum. The UDP payload is packed
// little-endian into 32-bit words, and each word is written into packet RAM.
//
// Ports:
//   clk            receive clock, rising edge
//   clr            asynchronous active-high reset
//   rxdv, rxer     receive data valid / receive error
//   datain[7:0]    receive byte, sampled when rxdv=1
//   ram_wr_en      one-cycle RAM write strobe
//   ram_wr_addr    RAM word address (ADDR_W bits)
//   ram_wr_data    packed payload word
//   rx_data_length payload byte count of the last completed frame
//   rx_done        one-cycle pulse per accepted, completed frame
//   rx_err         one-cycle pulse per aborted or filtered frame
//   rx_state[3:0]  current state, for debug
//   rx_pkt_cnt     count of rx_done pulses (wraps)
module udp_rx #(
   parameter logic [47:0] LOCAL_MAC  = 48'h000A3501FEC0,
   parameter logic [31:0] LOCAL_IP   = 32'hC0A80002,
   parameter logic [15:0] LOCAL_PORT = 16'h1F90,
   parameter int          ADDR_W     = 11,
   parameter int          RAM_BASE   = 0
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              rxdv,
   input  logic              rxer,
   input  logic [7:0]        datain,
   output logic              ram_wr_en,
   output logic [ADDR_W-1:0] ram_wr_addr,
   output logic [31:0]       ram_wr_data,
   output logic [15:0]       rx_data_length,
   output logic              rx_done,
   output logic              rx_err,
   output logic [3:0]        rx_state,
   output logic [15:0]       rx_pkt_cnt
);

   typedef enum logic [3:0] {
      IDLE     = 4'd0,
      PRE      = 4'd1,
      MAC      = 4'd2,
      IPHDR    = 4'd3,
      UDPHDR   = 4'd4,
      DATA     = 4'd5,
      WAIT_END = 4'd6,
      ERR      = 4'd7
   } state_t;

   // Largest payload, in bytes, that still fits between RAM_BASE and the top of RAM.
   localparam logic [31:0] MAX_PAY = 32'(4 * ((1 << ADDR_W) - RAM_BASE));

   state_t       state;
   logic [15:0]  cnt;
   logic [1:0]   pre_cnt;
   logic         fail;
   logic         mac_loc;
   logic         mac_bc;
   logic [7:0]   hi_byte;
   logic [19:0]  csum;
   logic [15:0]  ulen;
   logic [15:0]  pay_len;
   logic [23:0]  word;

   logic [19:0]  csum_nxt;
   logic [15:0]  pay;
   logic [31:0]  word_nxt;
   logic         byte_bad;
   logic         loc_hit;
   logic         bc_hit;
   logic         last_pay;

   function automatic logic [7:0] mac_byte(input logic [2:0] idx);
      return LOCAL_MAC[8*(5 - int'(idx)) +: 8];
   endfunction

   function automatic logic [7:0] ip_byte(input logic [1:0] idx);
      return IP_BYTE_SEL(idx);
   endfunction

   function automatic logic [7:0] IP_BYTE_SEL(input logic [1:0] idx);
      return LOCAL_IP[8*(3 - int'(idx)) +: 8];
   endfunction

   // Fold the carries of the 20-bit ones'-complement accumulator twice.
   function automatic logic [15:0] csum_fold(input logic [19:0] s);
      logic [19:0] f1;
      logic [19:0] f2;
      f1 = {4'd0, s[15:0]} + {16'd0, s[19:16]};
      f2 = {4'd0, f1[15:0]} + {16'd0, f1[19:16]};
      return f2[15:0];
   endfunction

   assign rx_state = state;

   always_comb begin
      csum_nxt = csum + {4'd0, hi_byte, datain};
      pay      = ulen - 16'd8;
      last_pay = (cnt == pay_len - 16'd1);
      loc_hit  = 1'b1;
      bc_hit   = 1'b1;
      if (cnt < 16'd6) begin
         loc_hit = (datain == mac_byte(cnt[2:0]));
         bc_hit  = (datain == 8'hFF);
      end
      // Lanes above the current byte are already zero because word is cleared after each write.
      case (cnt[1:0])
         2'd0:    word_nxt = {24'd0, datain};
         2'd1:    word_nxt = {16'd0, datain, word[7:0]};
         2'd2:    word_nxt = {8'd0, datain, word[15:0]};
         default: word_nxt = {datain, word[23:0]};
      endcase
      byte_bad = 1'b0;
      case (state)
         MAC: begin
            if (cnt == 16'd12) byte_bad = (datain != 8'h08);
            if (cnt == 16'd13) byte_bad = (datain != 8'h00);
         end
         IPHDR: begin
            if (cnt == 16'd0) byte_bad = (datain != 8'h45);
            if (cnt == 16'd9) byte_bad = (datain != 8'h11);
            if (cnt >= 16'd16 && cnt <= 16'd19) byte_bad = (datain != ip_byte(cnt[1:0]));
         end
         UDPHDR: begin
            if (cnt == 16'd2) byte_bad = (datain != LOCAL_PORT[15:8]);
            if (cnt == 16'd3) byte_bad = (datain != LOCAL_PORT[7:0]);
         end
         default: byte_bad = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state          <= IDLE;
         cnt            <= '0;
         pre_cnt        <= '0;
         fail           <= 1'b0;
         mac_loc        <= 1'b0;
         mac_bc         <= 1'b0;
         hi_byte        <= '0;
         csum           <= '0;
         ulen           <= '0;
         pay_len        <= '0;
         word           <= '0;
         ram_wr_en      <= 1'b0;
         ram_wr_addr    <= '0;
         ram_wr_data    <= '0;
         rx_data_length <= '0;
         rx_done        <= 1'b0;
         rx_err         <= 1'b0;
         rx_pkt_cnt     <= '0;
      end else begin
         ram_wr_en <= 1'b0;
         rx_done   <= 1'b0;
         rx_err    <= 1'b0;
         if (rxdv && rxer && state != IDLE && state != ERR) begin
            state  <= ERR;
            rx_err <= 1'b1;
         end else if (!rxdv) begin
            case (state)
               IDLE: state <= IDLE;
               WAIT_END: begin
                  rx_done        <= 1'b1;
                  rx_data_length <= pay_len;
                  rx_pkt_cnt     <= rx_pkt_cnt + 16'd1;
                  state          <= IDLE;
               end
               ERR: state <= IDLE;
               default: begin
                  rx_err <= 1'b1;
                  state  <= IDLE;
               end
            endcase
         end else begin
            case (state)
               IDLE: begin
                  if (datain == 8'h55) begin
                     state   <= PRE;
                     pre_cnt <= 2'd1;
                  end
               end
               PRE: begin
                  if (datain == 8'h55) begin
                     if (pre_cnt != 2'd2) pre_cnt <= pre_cnt + 2'd1;
                  end else if (datain == 8'hD5 && pre_cnt == 2'd2) begin
                     state   <= MAC;
                     cnt     <= '0;
                     fail    <= 1'b0;
                     mac_loc <= 1'b1;
                     mac_bc  <= 1'b1;
                  end else begin
                     state  <= ERR;
                     rx_err <= 1'b1;
                  end
               end
               MAC: begin
                  if (!loc_hit) mac_loc <= 1'b0;
                  if (!bc_hit) mac_bc <= 1'b0;
                  if (byte_bad) fail <= 1'b1;
                  if (cnt == 16'd13) begin
                     if (fail || byte_bad || !(mac_loc || mac_bc)) begin
                        state  <= ERR;
                        rx_err <= 1'b1;
                     end else begin
                        state <= IPHDR;
                        cnt   <= '0;
                        fail  <= 1'b0;
                        csum  <= '0;
                     end
                  end else begin
                     cnt <= cnt + 16'd1;
                  end
               end
               IPHDR: begin
                  if (!cnt[0]) hi_byte <= datain;
                  else csum <= csum_nxt;
                  if (byte_bad) fail <= 1'b1;
                  if (cnt == 16'd19) begin
                     if (fail || byte_bad || csum_fold(csum_nxt) != 16'hFFFF) begin
                        state  <= ERR;
                        rx_err <= 1'b1;
                     end else begin
                        state <= UDPHDR;
                        cnt   <= '0;
                        fail  <= 1'b0;
                     end
                  end else begin
                     cnt <= cnt + 16'd1;
                  end
               end
               UDPHDR: begin
                  if (byte_bad) fail <= 1'b1;
                  if (cnt == 16'd4) ulen[15:8] <= datain;
                  if (cnt == 16'd5) ulen[7:0] <= datain;
                  if (cnt == 16'd7) begin
                     pay_len <= pay;
                     cnt     <= '0;
                     word    <= '0;
                     if (fail || ulen < 16'd8 || {16'd0, pay} > MAX_PAY) begin
                        state  <= ERR;
                        rx_err <= 1'b1;
                     end else if (pay == 16'd0) begin
                        state <= WAIT_END;
                     end else begin
                        state <= DATA;
                     end
                  end else begin
                     cnt <= cnt + 16'd1;
                  end
               end
               DATA: begin
                  if (cnt[1:0] == 2'd3 || last_pay) begin
                     ram_wr_en   <= 1'b1;
                     ram_wr_data <= word_nxt;
                     ram_wr_addr <= ADDR_W'(RAM_BASE) + ADDR_W'(cnt >> 2);
                     word        <= '0;
                  end else begin
                     word <= word_nxt[23:0];
                  end
                  if (last_pay) state <= WAIT_END;
                  else cnt <= cnt + 16'd1;
               end
               WAIT_END: state <= WAIT_END;
               ERR: state <= ERR;
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
